// File: rtl/scan_chain_ctrl_pkg.sv
// Shared encodings for the two-phase scan chain master: op codes, FSM states
// and a small elaboration-time helper.
package scan_chain_ctrl_pkg;

  localparam logic OP_SHIFT   = 1'b0;
  localparam logic OP_CAPTURE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP1 = 3'd1,
    ST_PH1  = 3'd2,
    ST_GAP2 = 3'd3,
    ST_PH2  = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_chain_ctrl_phase_gen.sv
// Phase sequencer: times each GAP/PH state, drives the registered phi flops
// and flags the last cycle of the current state.
module scan_phase_gen
  import scan_chain_ctrl_pkg::*;
#(
  parameter int PHASE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_e state,
  input  state_e state_nxt,
  output logic   phi1,
  output logic   phi2,
  output logic   phase_last
);

  localparam int CNT_W = $clog2(max_int(PHASE_CYC, GAP_CYC) + 1);
  localparam logic [CNT_W-1:0] PH_LOAD  = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

  logic [CNT_W-1:0] phasecnt;

  // phis are decoded from the next state so they rise and fall on the same
  // edge as the state change; a non-overlap gap is guaranteed by GAP1/GAP2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phasecnt <= '0;
      phi1     <= 1'b0;
      phi2     <= 1'b0;
    end else begin
      phi1 <= (state_nxt == ST_PH1);
      phi2 <= (state_nxt == ST_PH2);
      if (state_nxt != state) begin
        case (state_nxt)
          ST_PH1, ST_PH2:   phasecnt <= PH_LOAD;
          ST_GAP1, ST_GAP2: phasecnt <= GAP_LOAD;
          default:          phasecnt <= '0;
        endcase
      end else if (phasecnt != '0) begin
        phasecnt <= phasecnt - CNT_W'(1);
      end
    end
  end

  assign phase_last = (phasecnt == '0);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Master for a chain of two-phase scan cells: serial SHIFT of a parallel word
// through the chain, or a single-phi2 CAPTURE of the cells' functional data.
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int PHASE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [CHAIN_LEN-1:0] wdata,
  output logic [CHAIN_LEN-1:0] rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 phi1,
  output logic                 phi2,
  output logic                 scan_enable,
  output logic                 scan_mode,
  output logic                 chain_in,
  input  logic                 chain_out
);

  if (CHAIN_LEN < 1 || PHASE_CYC < 1 || GAP_CYC < 1) begin : g_param_chk
    $error("scan_chain_ctrl: CHAIN_LEN, PHASE_CYC and GAP_CYC must all be >= 1");
  end

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);

  state_e               state;
  state_e               state_nxt;
  logic                 op_q;
  logic [BIT_W-1:0]     bitcnt;
  logic [CHAIN_LEN-1:0] wdata_sr;
  logic [CHAIN_LEN-1:0] rdata_sr;
  logic                 phase_last;
  logic                 bit_next;
  logic                 ph1_entry;
  logic                 fin_entry;

  scan_phase_gen #(
    .PHASE_CYC (PHASE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .state_nxt  (state_nxt),
    .phi1       (phi1),
    .phi2       (phi2),
    .phase_last (phase_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (op == OP_CAPTURE) ? ST_GAP2 : ST_GAP1;
      ST_GAP1: if (phase_last) state_nxt = ST_PH1;
      ST_PH1:  if (phase_last) state_nxt = ST_GAP2;
      ST_GAP2: if (phase_last) state_nxt = ST_PH2;
      ST_PH2:  if (phase_last)
                 state_nxt = (op_q == OP_CAPTURE || bitcnt == LAST_BIT) ? ST_FIN : ST_GAP1;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bit_next  = (state == ST_PH2) && (state_nxt == ST_GAP1);
  assign ph1_entry = (state != ST_PH1) && (state_nxt == ST_PH1);
  assign fin_entry = (state != ST_FIN) && (state_nxt == ST_FIN);

  // Control stage: op FSM, bit counter and all registered chain outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_SHIFT;
      bitcnt      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      scan_enable <= 1'b0;
      scan_mode   <= 1'b1;
      chain_in    <= 1'b0;
      rdata       <= '0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != ST_IDLE);
      scan_enable <= (state_nxt != ST_IDLE);
      done        <= fin_entry;
      if (state == ST_IDLE && start) begin
        op_q      <= op;
        scan_mode <= (op == OP_SHIFT);
        bitcnt    <= '0;
        if (op == OP_SHIFT) chain_in <= wdata[0];
      end
      if (bit_next) begin
        bitcnt   <= bitcnt + BIT_W'(1);
        chain_in <= wdata_sr[0];
      end
      if (fin_entry) begin
        chain_in <= 1'b0;
        if (op_q == OP_SHIFT) rdata <= rdata_sr;
      end
    end
  end

  // Data stage: serialiser for wdata and deserialiser for the returned word.
  // The first bit sampled from the tail cell lands in rdata[0].
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      wdata_sr <= wdata >> 1;
    end else if (bit_next) begin
      wdata_sr <= wdata_sr >> 1;
    end
    if (ph1_entry) begin
      rdata_sr <= (rdata_sr >> 1) | (CHAIN_LEN'(chain_out) << (CHAIN_LEN - 1));
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: eight modelled two-phase scan cells on the main
// instance, plus a second instance with PHASE_CYC=3/GAP_CYC=2 for timing.
module tb_scan_chain_ctrl;
  import scan_chain_ctrl_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         start = 1'b0, op = OP_SHIFT;
  logic [N-1:0] wdata = '0, rdata;
  logic         busy, done, phi1, phi2, scan_enable, scan_mode, chain_in, chain_out;

  logic         start2 = 1'b0, op2 = OP_SHIFT;
  logic [N-1:0] wdata2 = '0, rdata2;
  logic         busy2, done2, phi1b, phi2b, se2, sm2, ci2;
  logic         co2 = 1'b0;

  scan_chain_ctrl #(.CHAIN_LEN(N), .PHASE_CYC(2), .GAP_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .phi1(phi1), .phi2(phi2), .scan_enable(scan_enable),
    .scan_mode(scan_mode), .chain_in(chain_in), .chain_out(chain_out)
  );

  scan_chain_ctrl #(.CHAIN_LEN(N), .PHASE_CYC(3), .GAP_CYC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .wdata(wdata2), .rdata(rdata2),
    .busy(busy2), .done(done2), .phi1(phi1b), .phi2(phi2b), .scan_enable(se2),
    .scan_mode(sm2), .chain_in(ci2), .chain_out(co2)
  );

  // Behavioural chain: phi1 loads masters from the upstream slave, phi2 loads
  // slaves from their master (shift) or from functional data_in (capture).
  logic [N-1:0] mst, slv, cell_din;
  logic [N-1:0] cap_word = 8'h00;
  always_comb begin
    cell_din = '0;
    for (int j = 0; j < N; j++) cell_din[j] = cap_word[N-1-j];
  end
  assign chain_out = slv[N-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst <= '0;
      slv <= '0;
    end else begin
      if (phi1 && scan_enable && scan_mode) mst <= {slv[N-2:0], chain_in};
      if (phi2) slv <= scan_mode ? mst : cell_din;
    end
  end

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void chk_ge(input string name, input longint act, input longint lim);
    total++;
    if (act < lim) begin
      bad++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, lim);
    end
  endfunction

  typedef struct {
    logic [N-1:0] rdata;
    int           busy_len;
    bit           cap;
  } exp_t;

  exp_t q1[$];
  int   q2[$];

  // Monitor for the main instance: pops one expectation per done pulse.
  int   bcnt = 0, p1r = 0, p2r = 0, p2_sm1 = 0, p2_sm0 = 0, ov1 = 0;
  logic pp1 = 1'b0, pp2 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (phi1 && phi2) ov1++;
    if (busy) begin
      bcnt++;
      if (phi1 && !pp1) p1r++;
      if (phi2 && !pp2) p2r++;
      if (phi2 && scan_mode) p2_sm1++;
      if (phi2 && !scan_mode) p2_sm0++;
    end
    if (done) begin
      if (q1.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("busy_len", bcnt, e.busy_len);
        chk("phi1_pulses", p1r, e.cap ? 0 : N);
        chk("phi2_pulses", p2r, e.cap ? 1 : N);
        chk("phi2_scan_mode", e.cap ? p2_sm1 : p2_sm0, 0);
      end
    end
    if (!busy) begin
      bcnt = 0; p1r = 0; p2r = 0; p2_sm1 = 0; p2_sm0 = 0;
    end
    pp1 = phi1;
    pp2 = phi2;
  end

  // Monitor for the slow-phase instance: pulse widths, gaps and busy length.
  int   b2cnt = 0, low_run = 0, hi_run = 0, ov2 = 0;
  logic qp1 = 1'b0, qp2 = 1'b0;
  always @(negedge clk) begin
    if (phi1b && phi2b) ov2++;
    if ((phi1b && !qp1) || (phi2b && !qp2)) begin
      if (busy2) chk_ge("gap_before_phi", low_run, 2);
      low_run = 0;
    end
    if (!phi1b && !phi2b) begin
      if (hi_run != 0) chk("phi_width", hi_run, 3);
      hi_run = 0;
      low_run++;
    end else begin
      hi_run++;
    end
    if (busy2) b2cnt++;
    if (done2) begin
      if (q2.size() == 0) chk("unexpected_done2", 1, 0);
      else chk("busy2_len", b2cnt, q2.pop_front());
    end
    if (!busy2) b2cnt = 0;
    qp1 = phi1b;
    qp2 = phi2b;
  end

  logic [N-1:0] content = '0;
  logic [N-1:0] last_r  = '0;

  task automatic issue(input logic o, input logic [N-1:0] w);
    @(posedge clk); #1;
    op = o; wdata = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk({name, "_timeout"}, 1, 0);
    @(negedge clk);
  endtask

  task automatic do_shift(input logic [N-1:0] w);
    q1.push_back('{content, 2*N*3+1, 1'b0});
    issue(OP_SHIFT, w);
    last_r  = content;
    content = w;
    wait_idle("shift");
  endtask

  task automatic do_capture();
    q1.push_back('{last_r, 4, 1'b1});
    issue(OP_CAPTURE, '0);
    content = cap_word;
    wait_idle("capture");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   cnt;
    logic pv;

    // Reset values
    #12;
    chk("rst_phi1", phi1, 0);
    chk("rst_phi2", phi2, 0);
    chk("rst_scan_enable", scan_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_scan_mode", scan_mode, 1);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_chain_in", chain_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read back through the chain
    do_shift(8'hA5);
    do_shift(8'h3C);

    // Capture functional data, then shift it out
    cap_word = 8'h5A;
    do_capture();
    chk("capture_keeps_rdata", rdata, 8'hA5);
    chk("capture_scan_mode", scan_mode, 0);
    do_shift(8'h00);

    // Starts during PH1 of bit 2 and during FIN must be ignored
    q1.push_back('{content, 2*N*3+1, 1'b0});
    issue(OP_SHIFT, 8'h96);
    last_r  = content;
    content = 8'h96;
    cnt = 0; n = 0; pv = phi1;
    while (cnt < 3 && n < 500) begin
      @(negedge clk);
      if (phi1 && !pv) cnt++;
      pv = phi1;
      n++;
    end
    if (n >= 500) chk("ph1_bit2_timeout", 1, 0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("done_timeout", 1, 0);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(negedge clk);
    chk("fin_start_ignored", busy, 0);
    chk("rdata_after_ignored", rdata, 8'h00);

    // Slow-phase instance timing
    q2.push_back(2*N*5+1);
    @(posedge clk); #1; op2 = OP_SHIFT; wdata2 = 8'hC3; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    n = 0;
    while (busy2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("busy2_timeout", 1, 0);
    @(negedge clk);
    chk("rdata2", rdata2, 8'h00);
    chk("se2_idle", se2, 0);
    chk("sm2_shift", sm2, 1);
    chk("ci2_idle", ci2, 0);

    // Reset in the middle of a shift
    issue(OP_SHIFT, 8'hFF);
    cnt = 0; n = 0; pv = phi2;
    while (cnt < 3 && n < 500) begin
      @(negedge clk);
      if (!phi2 && pv) cnt++;
      pv = phi2;
      n++;
    end
    if (n >= 500) chk("bit3_timeout", 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_phi1", phi1, 0);
    chk("midrst_phi2", phi2, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_scan_enable", scan_enable, 0);
    chk("midrst_rdata", rdata, 8'h00);
    chk("midrst_scan_mode", scan_mode, 1);
    content = '0;
    last_r  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_shift(8'hFF);
    do_shift(8'h00);

    repeat (5) @(negedge clk);
    chk("overlap_main", ov1, 0);
    chk("overlap_slow", ov2, 0);
    chk("queues_drained", q1.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
